// File: rtl/z80_dram_pkg.sv
// z80_dram_pkg
// Shared types and constants for the Z80-to-DRAM arbiter bridge.
//   port_state_t : bridge FSM states (IDLE, REQ, WAITRD, DONE)
//   WADDR_W      : arbiter word-address width (21)
//   WDATA_W      : arbiter word-data width (16)
//   byte_lane()  : picks the byte of a 16-bit word addressed by byte-address bit 0
package z80_dram_pkg;

  localparam int WADDR_W = 21;
  localparam int WDATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAITRD = 2'd2,
    DONE   = 2'd3
  } port_state_t;

  // Lane 0 is the low byte of the word and lane 1 is the high byte.
  function automatic logic [7:0] byte_lane(input logic [WDATA_W-1:0] word,
                                           input logic               sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/zport_wcache.sv
// zport_wcache
// One-entry 16-bit read cache for z80_dram_port (built only with WORD_CACHE_EN).
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset (clears valid)
//   lookup_addr     : word address of the read being started
//   hit, hit_word   : tag match with valid entry, and the cached word
//   fill            : one-clock pulse loading fill_addr/fill_data and setting valid
//   wr_upd          : accepted write; updates the cached byte if wr_addr matches the tag
//   wr_addr, wr_bsel, wr_data : the accepted write's word address, lane and byte
module zport_wcache
  import z80_dram_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WADDR_W-1:0] lookup_addr,
  output logic               hit,
  output logic [WDATA_W-1:0] hit_word,
  input  logic               fill,
  input  logic [WADDR_W-1:0] fill_addr,
  input  logic [WDATA_W-1:0] fill_data,
  input  logic               wr_upd,
  input  logic [WADDR_W-1:0] wr_addr,
  input  logic               wr_bsel,
  input  logic [7:0]         wr_data
);

  logic [WADDR_W-1:0] tag_q;
  logic [WDATA_W-1:0] data_q;
  logic               valid_q;

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_word = data_q;

  // A fill replaces the whole entry; a write-through only touches the one byte
  // of a word that is already cached, so the entry never holds stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (fill) begin
      tag_q   <= fill_addr;
      data_q  <= fill_data;
      valid_q <= 1'b1;
    end else if (wr_upd && valid_q && (tag_q == wr_addr)) begin
      if (wr_bsel) data_q[15:8] <= wr_data;
      else         data_q[7:0]  <= wr_data;
    end
  end

endmodule

// File: rtl/z80_dram_port.sv
// z80_dram_port
// Turns each Z80 byte memory cycle into one transaction on the arbiter's CPU
// port (16-bit words), holding the Z80 in WAIT until the transaction is done.
// Optional feature macro: WORD_CACHE_EN (one-entry read cache, zport_wcache).
// Ports:
//   clk, rst_n                 : system clock, asynchronous active-low reset
//   z_mreq_n, z_rd_n, z_wr_n   : clk-synchronised Z80 strobes
//   z_addr, z_dout             : mapped byte address, Z80 write data
//   z_din, z_wait_n            : read byte (held until the cycle ends), WAIT
//   cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel : request to the arbiter
//   cpu_stall, cpu_strobe, cpu_rddata                  : responses from the arbiter
module z80_dram_port
  import z80_dram_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               z_mreq_n,
  input  logic               z_rd_n,
  input  logic               z_wr_n,
  input  logic [21:0]        z_addr,
  input  logic [7:0]         z_dout,
  output logic [7:0]         z_din,
  output logic               z_wait_n,
  output logic               cpu_req,
  output logic               cpu_rnw,
  output logic [WADDR_W-1:0] cpu_addr,
  output logic [7:0]         cpu_wrdata,
  output logic               cpu_wrbsel,
  input  logic               cpu_stall,
  input  logic               cpu_strobe,
  input  logic [WDATA_W-1:0] cpu_rddata
);

  port_state_t        state_q, state_d;
  logic               req_rnw_q;
  logic [WADDR_W-1:0] req_addr_q;
  logic [7:0]         req_wrdata_q;
  logic               req_bsel_q;

  logic               start;
  logic               start_rd;
  logic               accept;
  logic               fill;
  logic               cache_hit;
  logic [WDATA_W-1:0] cache_word;
  logic               take_hit;

  // Refresh cycles (MREQ with neither RD nor WR) never start a cycle; RD wins
  // if both strobes are low.
  assign start    = (state_q == IDLE) && !z_mreq_n && (!z_rd_n || !z_wr_n);
  assign start_rd = !z_rd_n;
  assign accept   = (state_q == REQ) && !cpu_stall;
  assign fill     = (state_q == WAITRD) && cpu_strobe;
  assign take_hit = start && start_rd && cache_hit;

`ifdef WORD_CACHE_EN
  zport_wcache u_wcache (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_addr (z_addr[21:1]),
    .hit         (cache_hit),
    .hit_word    (cache_word),
    .fill        (fill),
    .fill_addr   (req_addr_q),
    .fill_data   (cpu_rddata),
    .wr_upd      (accept && !req_rnw_q),
    .wr_addr     (req_addr_q),
    .wr_bsel     (req_bsel_q),
    .wr_data     (req_wrdata_q)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state. A cache hit skips the arbiter entirely; a posted write is
  // finished as soon as the arbiter accepts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = take_hit ? DONE : REQ;
      REQ:     if (!cpu_stall) state_d = req_rnw_q ? WAITRD : DONE;
      WAITRD:  if (cpu_strobe) state_d = DONE;
      DONE:    if (z_mreq_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request registers are loaded only at cycle start so the arbiter sees a
  // frozen request however long it stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rnw_q    <= 1'b1;
      req_addr_q   <= '0;
      req_wrdata_q <= '0;
      req_bsel_q   <= 1'b0;
    end else if (start) begin
      req_rnw_q    <= start_rd;
      req_addr_q   <= z_addr[21:1];
      req_wrdata_q <= z_dout;
      req_bsel_q   <= z_addr[0];
    end
  end

  // Read byte to the Z80: loaded from the arbiter strobe or a cache hit and
  // otherwise held, so it stays stable through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        z_din <= 8'hFF;
    else if (fill)     z_din <= byte_lane(cpu_rddata, req_bsel_q);
    else if (take_hit) z_din <= byte_lane(cache_word, z_addr[0]);
  end

  assign cpu_req    = (state_q == REQ);
  assign cpu_rnw    = req_rnw_q;
  assign cpu_addr   = req_addr_q;
  assign cpu_wrdata = req_wrdata_q;
  assign cpu_wrbsel = req_bsel_q;
  assign z_wait_n   = !((state_q == REQ) || (state_q == WAITRD));

endmodule
